// File: rtl/csa_add_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract engine: one 8-bit slice is reused LSB byte first,
// with the carry held in a register between bytes.

// 8-bit slice adder. All cin bits carry weight 1 at bit 0; cout is bit 8 of the total.
module csa_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [4:0] cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [2:0] cin_count;
  logic [8:0] total;

  always_comb begin
    cin_count = {2'b00, cin[0]} + {2'b00, cin[1]} + {2'b00, cin[2]}
              + {2'b00, cin[3]} + {2'b00, cin[4]};
    total     = {1'b0, a} + {1'b0, b} + {6'b0, cin_count};
  end

  assign sum  = total[7:0];
  assign cout = total[8];
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high only in IDLE and out_valid only in DONE; they are never high together.
module csa_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  localparam int NSLICE = WIDTH / 8;
  localparam int IDXW   = $clog2(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx;
  logic [7:0]       slice_a;
  logic [7:0]       slice_b;
  logic [7:0]       slice_sum;
  logic             slice_cout;

  assign slice_a   = opa_reg[idx*8 +: 8];
  assign slice_b   = opb_reg[idx*8 +: 8];
  assign dbg_state = state;

  csa_adder_8bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  ({4'b0000, carry_reg}),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      data_result <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      carry_reg   <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            opa_reg     <= data_operandA;
            opb_reg     <= ctrl_sub ? ~data_operandB : data_operandB;
            carry_reg   <= ctrl_sub;
            idx         <= '0;
            data_result <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          data_result[idx*8 +: 8] <= slice_sum;
          carry_reg               <= slice_cout;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            carry_out <= slice_cout;
            overflow  <= (opa_reg[WIDTH-1] == opb_reg[WIDTH-1]) &&
                         (slice_sum[7] != opa_reg[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csa_add_sequencer.sv
// Bench for csa_add_sequencer (WIDTH=32): directed corner cases, random ops against an
// arithmetic reference model, backpressure, mid-run reset and back-to-back traffic.
module tb_csa_add_sequencer;
  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ctrl_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_result;
  logic         carry_out;
  logic         overflow;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  csa_add_sequencer #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_sub      (ctrl_sub),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_result   (data_result),
    .carry_out     (carry_out),
    .overflow      (overflow),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain wide arithmetic and the textbook overflow rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         ov;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     full = {1'b0, a} + {1'b0, b};
    r = full[W-1:0];
    if (sub) ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else     ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {ov, full[W], r};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction: accept, latency, result, optional backpressure, handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold, input string name);
    logic [W+1:0] exp;
    logic [W-1:0] exp_r;
    int cyc;
    exp = model(a, b, sub);
    exp_q.push_back(exp[W-1:0]);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s in_ready timeout: got %0b want 1", name, in_ready);
      return;
    end
    data_operandA = a;
    data_operandB = b;
    ctrl_sub      = sub;
    in_valid      = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s run flags: got rdy=%0b busy=%0b ov=%0b want 0 1 0",
               name, in_ready, busy, out_valid);
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles want 4", name, cyc);
    end
    exp_r = exp_q.pop_front();
    checks++;
    if (data_result !== exp_r || carry_out !== exp[W] || overflow !== exp[W+1]) begin
      errors++;
      $display("FAIL %s result: got %h c=%0b v=%0b want %h c=%0b v=%0b", name,
               data_result, carry_out, overflow, exp_r, exp[W], exp[W+1]);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid      = 1'b1;
      data_operandA = $urandom;
      data_operandB = $urandom;
      ctrl_sub      = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (data_result !== exp_r || carry_out !== exp[W] || overflow !== exp[W+1] ||
          out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s hold[%0d]: got %h c=%0b v=%0b ov=%0b rdy=%0b want %h c=%0b v=%0b 1 0",
                 name, i, data_result, carry_out, overflow, out_valid, in_ready,
                 exp_r, exp[W], exp[W+1]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: got ov=%0b rdy=%0b busy=%0b want 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_sub = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        data_result !== '0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b ov=%0b busy=%0b r=%h c=%0b v=%0b want 1 0 0 0 0 0",
               in_ready, out_valid, busy, data_result, carry_out, overflow);
    end
  endtask

  task automatic test_directed();
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, "add_max_pos");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "add_carry_chain");
    run_op(32'h00000005, 32'h00000007, 1'b1, 0, "sub_borrow");
    run_op(32'h80000000, 32'h00000001, 1'b1, 0, "sub_min_neg");
    run_op(32'h00000000, 32'h00000000, 1'b1, 0, "sub_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, "random");
  endtask

  task automatic test_backpressure();
    run_op(32'hDEADBEEF, 32'h01234567, 1'b0, 10, "backpressure");
  endtask

  task automatic test_reset_mid_run();
    int seen;
    data_operandA = 32'hAAAAAAAA;
    data_operandB = 32'h55555555;
    ctrl_sub      = 1'b0;
    in_valid      = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        data_result !== '0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: got rdy=%0b ov=%0b busy=%0b r=%h want 1 0 0 0",
               in_ready, out_valid, busy, data_result);
    end
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abandoned_op_result: got %0d out_valid cycles want 0", seen);
    end
    run_op(32'h12345678, 32'h11111111, 1'b0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, 1'(i % 2), 0, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
